// File: rtl/dbg_guv.sv
// In-line debug governor for five AXI-Stream channels: transparent pass-through,
// with a command stream that can pause/resume all channels or drop/inject one beat.
module dbg_guv #(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 16
) (
  input  logic                  CLOCK_50,
  input  logic                  rst,
  input  logic [31:0]           cmd_in_TDATA,
  input  logic                  cmd_in_TVALID,
  output logic                  cmd_in_TREADY,
  input  logic [DATA_WIDTH-1:0] din_TDATA_rdata,
  input  logic [DEST_WIDTH-1:0] din_TDEST_rdata,
  input  logic                  din_TVALID_rdata,
  output logic                  din_TREADY_rdata,
  input  logic [DATA_WIDTH-1:0] din_TDATA_wdata,
  input  logic                  din_TVALID_wdata,
  output logic                  din_TREADY_wdata,
  input  logic [DATA_WIDTH-1:0] din_TDATA_raddr,
  input  logic                  din_TVALID_raddr,
  output logic                  din_TREADY_raddr,
  input  logic [DATA_WIDTH-1:0] din_TDATA_awaddr,
  input  logic                  din_TVALID_awaddr,
  output logic                  din_TREADY_awaddr,
  input  logic [DATA_WIDTH-1:0] din_TDATA_resp,
  input  logic                  din_TVALID_resp,
  output logic                  din_TREADY_resp,
  output logic [DATA_WIDTH-1:0] dout_TDATA_rdata,
  output logic [DEST_WIDTH-1:0] dout_TDEST_rdata,
  output logic                  dout_TVALID_rdata,
  input  logic                  dout_TREADY_rdata,
  output logic [DATA_WIDTH-1:0] dout_TDATA_wdata,
  output logic                  dout_TVALID_wdata,
  input  logic                  dout_TREADY_wdata,
  output logic [DATA_WIDTH-1:0] dout_TDATA_raddr,
  output logic                  dout_TVALID_raddr,
  input  logic                  dout_TREADY_raddr,
  output logic [DATA_WIDTH-1:0] dout_TDATA_awaddr,
  output logic                  dout_TVALID_awaddr,
  input  logic                  dout_TREADY_awaddr,
  output logic [DATA_WIDTH-1:0] dout_TDATA_resp,
  output logic                  dout_TVALID_resp,
  input  logic                  dout_TREADY_resp
);

  localparam int NCH = 5;

  typedef enum logic [1:0] {IDLE, DROP_WAIT, INJECT_WAIT} state_t;

  localparam logic [2:0] OP_PAUSE  = 3'd1;
  localparam logic [2:0] OP_RUN    = 3'd2;
  localparam logic [2:0] OP_DROP   = 3'd3;
  localparam logic [2:0] OP_INJECT = 3'd4;

  state_t      state_q, state_d;
  logic        run_q, run_d;
  logic [2:0]  chan_q, chan_d;
  logic [25:0] payload_q, payload_d;

  logic [DATA_WIDTH-1:0] din_data  [NCH];
  logic [DATA_WIDTH-1:0] dout_data [NCH];
  logic [NCH-1:0]        din_vld, din_rdy, dout_vld, dout_rdy;
  logic [DEST_WIDTH-1:0] dout_dest;
  logic                  sel_din_vld, sel_dout_rdy;

  assign din_data[0] = din_TDATA_rdata;
  assign din_data[1] = din_TDATA_wdata;
  assign din_data[2] = din_TDATA_raddr;
  assign din_data[3] = din_TDATA_awaddr;
  assign din_data[4] = din_TDATA_resp;
  assign din_vld  = {din_TVALID_resp, din_TVALID_awaddr, din_TVALID_raddr,
                     din_TVALID_wdata, din_TVALID_rdata};
  assign dout_rdy = {dout_TREADY_resp, dout_TREADY_awaddr, dout_TREADY_raddr,
                     dout_TREADY_wdata, dout_TREADY_rdata};

  assign dout_TDATA_rdata  = dout_data[0];
  assign dout_TDATA_wdata  = dout_data[1];
  assign dout_TDATA_raddr  = dout_data[2];
  assign dout_TDATA_awaddr = dout_data[3];
  assign dout_TDATA_resp   = dout_data[4];
  assign dout_TDEST_rdata  = dout_dest;
  assign {dout_TVALID_resp, dout_TVALID_awaddr, dout_TVALID_raddr,
          dout_TVALID_wdata, dout_TVALID_rdata} = dout_vld;
  assign {din_TREADY_resp, din_TREADY_awaddr, din_TREADY_raddr,
          din_TREADY_wdata, din_TREADY_rdata} = din_rdy;

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      run_q     <= 1'b1;
      chan_q    <= 3'd0;
      payload_q <= 26'd0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      chan_q    <= chan_d;
      payload_q <= payload_d;
    end
  end

  always_comb begin
    sel_din_vld  = 1'b0;
    sel_dout_rdy = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (chan_q == 3'(i)) begin
        sel_din_vld  = din_vld[i];
        sel_dout_rdy = dout_rdy[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    chan_d    = chan_q;
    payload_d = payload_q;
    case (state_q)
      IDLE: begin
        if (cmd_in_TVALID) begin
          case (cmd_in_TDATA[2:0])
            OP_PAUSE: run_d = 1'b0;
            OP_RUN:   run_d = 1'b1;
            OP_DROP, OP_INJECT: begin
              // Out-of-range channels are swallowed as a no-op.
              if (cmd_in_TDATA[5:3] < 3'd5) begin
                chan_d    = cmd_in_TDATA[5:3];
                payload_d = cmd_in_TDATA[31:6];
                state_d   = (cmd_in_TDATA[2:0] == OP_DROP) ? DROP_WAIT : INJECT_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      DROP_WAIT:   if (sel_din_vld)  state_d = IDLE;
      INJECT_WAIT: if (sel_dout_rdy) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_in_TREADY = (state_q == IDLE) && !rst;
    dout_dest     = din_TDEST_rdata;
    for (int i = 0; i < NCH; i++) begin
      dout_data[i] = din_data[i];
      dout_vld[i]  = run_q & din_vld[i];
      din_rdy[i]   = run_q & dout_rdy[i];
      if (chan_q == 3'(i) && state_q == DROP_WAIT) begin
        dout_vld[i] = 1'b0;
        din_rdy[i]  = 1'b1;
      end else if (chan_q == 3'(i) && state_q == INJECT_WAIT) begin
        dout_data[i] = {{(DATA_WIDTH-26){1'b0}}, payload_q};
        dout_vld[i]  = 1'b1;
        din_rdy[i]   = 1'b0;
      end
    end
    if (chan_q == 3'd0 && state_q == INJECT_WAIT && !run_q) dout_dest = din_TDEST_rdata;
    if (chan_q == 3'd0 && state_q == INJECT_WAIT) dout_dest = '0;
  end

endmodule

// File: tb/tb_dbg_guv.sv
// Directed bench for dbg_guv: pass-through, pause/run, inject, drop, reset abort, invalid channel.
module tb_dbg_guv;

  localparam int DW = 64;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cmd_TDATA;
  logic          cmd_TVALID, cmd_TREADY;
  logic [DW-1:0] di_d_rd, di_d_wd, di_d_ra, di_d_aw, di_d_rs;
  logic [TW-1:0] di_dest, do_dest;
  logic          di_v_rd, di_v_wd, di_v_ra, di_v_aw, di_v_rs;
  logic          di_r_rd, di_r_wd, di_r_ra, di_r_aw, di_r_rs;
  logic [DW-1:0] do_d_rd, do_d_wd, do_d_ra, do_d_aw, do_d_rs;
  logic          do_v_rd, do_v_wd, do_v_ra, do_v_aw, do_v_rs;
  logic          do_r_rd, do_r_wd, do_r_ra, do_r_aw, do_r_rs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbg_guv #(.DATA_WIDTH(DW), .DEST_WIDTH(TW)) dut (
    .CLOCK_50(clk), .rst(rst),
    .cmd_in_TDATA(cmd_TDATA), .cmd_in_TVALID(cmd_TVALID), .cmd_in_TREADY(cmd_TREADY),
    .din_TDATA_rdata(di_d_rd), .din_TDEST_rdata(di_dest),
    .din_TVALID_rdata(di_v_rd), .din_TREADY_rdata(di_r_rd),
    .din_TDATA_wdata(di_d_wd), .din_TVALID_wdata(di_v_wd), .din_TREADY_wdata(di_r_wd),
    .din_TDATA_raddr(di_d_ra), .din_TVALID_raddr(di_v_ra), .din_TREADY_raddr(di_r_ra),
    .din_TDATA_awaddr(di_d_aw), .din_TVALID_awaddr(di_v_aw), .din_TREADY_awaddr(di_r_aw),
    .din_TDATA_resp(di_d_rs), .din_TVALID_resp(di_v_rs), .din_TREADY_resp(di_r_rs),
    .dout_TDATA_rdata(do_d_rd), .dout_TDEST_rdata(do_dest),
    .dout_TVALID_rdata(do_v_rd), .dout_TREADY_rdata(do_r_rd),
    .dout_TDATA_wdata(do_d_wd), .dout_TVALID_wdata(do_v_wd), .dout_TREADY_wdata(do_r_wd),
    .dout_TDATA_raddr(do_d_ra), .dout_TVALID_raddr(do_v_ra), .dout_TREADY_raddr(do_r_ra),
    .dout_TDATA_awaddr(do_d_aw), .dout_TVALID_awaddr(do_v_aw), .dout_TREADY_awaddr(do_r_aw),
    .dout_TDATA_resp(do_d_rs), .dout_TVALID_resp(do_v_rs), .dout_TREADY_resp(do_r_rs)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command and wait (bounded) for it to be accepted.
  task automatic send_cmd(input logic [31:0] c);
    bit done = 1'b0;
    cmd_TDATA  = c;
    cmd_TVALID = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (cmd_TREADY) done = 1'b1;
      tick();
    end
    cmd_TVALID = 1'b0;
    cmd_TDATA  = '0;
    if (!done) chk("cmd_accept_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_TDATA = '0; cmd_TVALID = 1'b0;
    di_d_rd = '0; di_d_wd = '0; di_d_ra = '0; di_d_aw = '0; di_d_rs = '0; di_dest = '0;
    {di_v_rd, di_v_wd, di_v_ra, di_v_aw, di_v_rs} = '0;
    {do_r_rd, do_r_wd, do_r_ra, do_r_aw, do_r_rs} = '1;
    tick();
    #1 chk("rst_cmd_ready", cmd_TREADY, 0);
    tick();
    rst = 1'b0;
    #1 chk("idle_cmd_ready", cmd_TREADY, 1);

    // pass-through, zero latency
    di_d_wd = 64'h1234; di_v_wd = 1'b1;
    #1;
    chk("pt_wd_data", do_d_wd, 64'h1234);
    chk("pt_wd_vld", do_v_wd, 1);
    chk("pt_wd_rdy", di_r_wd, 1);

    // pause then run
    di_d_rd = 64'h77; di_v_rd = 1'b1; di_dest = 16'h5A5A;
    send_cmd(32'h1);
    #1;
    chk("pause_wd_vld", do_v_wd, 0);
    chk("pause_wd_rdy", di_r_wd, 0);
    chk("pause_rd_vld", do_v_rd, 0);
    chk("pause_rs_rdy", di_r_rs, 0);
    chk("pause_wd_data_vis", do_d_wd, 64'h1234);
    send_cmd(32'h2);
    #1;
    chk("run_wd_vld", do_v_wd, 1);
    chk("run_rd_rdy", di_r_rd, 1);
    chk("run_rd_dest", do_dest, 16'h5A5A);

    // inject 0x3F on wdata with downstream stalled
    do_r_wd = 1'b0;
    send_cmd((32'h3F << 6) | (32'd1 << 3) | 32'd4);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("inj_vld", do_v_wd, 1);
      chk("inj_data", do_d_wd, 64'h3F);
      chk("inj_din_rdy", di_r_wd, 0);
      chk("inj_cmd_rdy", cmd_TREADY, 0);
      tick();
    end
    do_r_wd = 1'b1;
    #1 chk("inj_accept_vld", do_v_wd, 1);
    tick();
    #1;
    chk("inj_done_cmd_rdy", cmd_TREADY, 1);
    chk("inj_done_wd_data", do_d_wd, 64'h1234);

    // inject on rdata forces TDEST to zero
    do_r_rd = 1'b0;
    send_cmd((32'h15 << 6) | 32'd4);
    #1;
    chk("inj_rd_dest", do_dest, 0);
    chk("inj_rd_data", do_d_rd, 64'h15);
    do_r_rd = 1'b1;
    tick();

    // drop one rdata beat
    di_v_rd = 1'b0;
    send_cmd(32'h3);
    #1;
    chk("drop_cmd_rdy", cmd_TREADY, 0);
    chk("drop_wait_rdy", di_r_rd, 1);
    di_d_rd = 64'hAA; di_v_rd = 1'b1;
    #1;
    chk("drop_beat_rdy", di_r_rd, 1);
    chk("drop_beat_vld", do_v_rd, 0);
    tick();
    di_d_rd = 64'hBB;
    #1;
    chk("drop_next_vld", do_v_rd, 1);
    chk("drop_next_data", do_d_rd, 64'hBB);
    chk("drop_done_cmd_rdy", cmd_TREADY, 1);

    // drop on resp pending, other channels flow, then reset aborts it
    di_v_rs = 1'b0; do_r_rs = 1'b0;
    send_cmd((32'd4 << 3) | 32'd3);
    di_d_aw = 64'hA0; di_v_aw = 1'b1; di_d_ra = 64'hB0; di_v_ra = 1'b1;
    #1;
    chk("dr_rs_rdy", di_r_rs, 1);
    chk("dr_rs_vld", do_v_rs, 0);
    chk("dr_aw_data", do_d_aw, 64'hA0);
    chk("dr_aw_vld", do_v_aw, 1);
    chk("dr_ra_vld", do_v_ra, 1);
    chk("dr_ra_rdy", di_r_ra, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_cmd_rdy", cmd_TREADY, 0);
    chk("abort_rs_rdy", di_r_rs, 0);
    tick();
    rst = 1'b0;
    di_v_rs = 1'b1; do_r_rs = 1'b1;
    #1;
    chk("abort_rel_cmd_rdy", cmd_TREADY, 1);
    chk("abort_rs_vld", do_v_rs, 1);
    chk("abort_rs_rdy_pt", di_r_rs, 1);

    // invalid channel drop is a no-op
    send_cmd((32'd6 << 3) | 32'd3);
    #1;
    chk("inv_cmd_rdy", cmd_TREADY, 1);
    chk("inv_rd_vld", do_v_rd, 1);
    chk("inv_rs_vld", do_v_rs, 1);
    chk("inv_wd_rdy", di_r_wd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbg_guv.md
# dbg_guv

Debug governor inserted in-line on the five AXI-Stream channels of a memory-mapped link: rdata, wdata, raddr, awaddr and resp. It passes traffic through transparently by default. A 32-bit command stream can pause or resume all channels, drop one beat on a chosen channel, or inject one beat on a chosen channel. It sits between the bus master adapter and the slave adapter, under control of a host debug controller.

## Interface
Parameters:
- DATA_WIDTH, 64, TDATA width of every channel.
- DEST_WIDTH, 16, TDEST width of the rdata channel.

Ports. `<ch>` ∈ {rdata, wdata, raddr, awaddr, resp}; port order is as listed, with channels in that order.
- CLOCK_50  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_in_TDATA  in  32  command word.
- cmd_in_TVALID  in  1  command valid.
- cmd_in_TREADY  out  1  command accepted when high together with TVALID.
- din_TDATA_`<ch>`  in  DATA_WIDTH  upstream data.
- din_TDEST_rdata  in  DEST_WIDTH  upstream dest (rdata only; appears after din_TDATA_rdata).
- din_TVALID_`<ch>`  in  1  upstream valid.
- din_TREADY_`<ch>`  out  1  upstream ready.
- dout_TDATA_`<ch>`  out  DATA_WIDTH  downstream data.
- dout_TDEST_rdata  out  DEST_WIDTH  downstream dest (rdata only).
- dout_TVALID_`<ch>`  out  1  downstream valid.
- dout_TREADY_`<ch>`  in  1  downstream ready.

## Operation
Command word fields:
- cmd[2:0] opcode: 0 NOP, 1 PAUSE, 2 RUN, 3 DROP, 4 INJECT; 5–7 are treated as NOP.
- cmd[5:3] channel: 0 rdata, 1 wdata, 2 raddr, 3 awaddr, 4 resp; 5–7 are invalid.
- cmd[31:6] inject payload, zero-extended to DATA_WIDTH.

Registered state:
- `run` flag (reset 1).
- FSM state ∈ {IDLE, DROP_WAIT, INJECT_WAIT} (reset IDLE).
- Selected channel (3 bits) and payload (26 bits).

FSM:
- IDLE: cmd_in_TREADY=1. On cmd_in_TVALID:
  - PAUSE: run←0.
  - RUN: run←1.
  - DROP with a valid channel → DROP_WAIT.
  - INJECT with a valid channel → INJECT_WAIT.
  - DROP/INJECT with an invalid channel, or NOP: accepted, no effect.
- DROP_WAIT: cmd_in_TREADY=0. Selected channel drives din_TREADY=1 and dout_TVALID=0. The first cycle with din_TVALID=1 consumes and discards that beat → IDLE.
- INJECT_WAIT: cmd_in_TREADY=0. Selected channel drives dout_TVALID=1, dout_TDATA=payload (dout_TDEST_rdata=0 for rdata), din_TREADY=0. The first cycle with dout_TREADY=1 completes the transfer → IDLE.

Per-channel datapath (combinational):
- Overridden when the channel is the selected channel of a pending DROP/INJECT; the override applies regardless of `run`.
- Otherwise, if run=1: dout_TDATA/TDEST=din, dout_TVALID=din_TVALID, din_TREADY=dout_TREADY.
- Otherwise (run=0): dout_TVALID=0 and din_TREADY=0; dout_TDATA=din_TDATA for visibility.
- Non-selected channels follow the run rules while a DROP/INJECT is pending.

## Timing
- Command handshake completes on a rising edge with cmd_in_TVALID & cmd_in_TREADY; its effect is visible from the next cycle (one-cycle latency).
- At most one DROP/INJECT is outstanding. New commands are back-pressured until the FSM returns to IDLE.
- Drop/inject beat completes on the edge where the channel handshake fires; cmd_in_TREADY rises in the following cycle.
- An inject beat holds TVALID/TDATA stable until accepted, per AXI-Stream rules.
- Reset asserted (asynchronously):
  - State returns to IDLE, run=1; payload and channel are cleared.
  - cmd_in_TREADY=0 while rst is high.
  - Every channel is in pass-through.
  - A pending drop/inject is abandoned with no partial beat.
- PAUSE while in DROP_WAIT/INJECT_WAIT is impossible; the command is back-pressured.
- Simultaneous upstream valid and downstream ready in pass-through: the beat transfers in that same cycle (zero latency, no buffering).

## Test plan
- Reset, run=1: din_TDATA_wdata=0x1234 with TVALID=1, dout_TREADY_wdata=1 -> dout_TDATA_wdata=0x1234, dout_TVALID_wdata=1, din_TREADY_wdata=1 in the same cycle; cmd_in_TREADY=1.
- Send PAUSE (0x00000001) -> from the next cycle all dout_TVALID=0 and all din_TREADY=0. Send RUN (0x00000002) -> pass-through restored the next cycle.
- INJECT wdata with payload 0x3F (cmd=(0x3F<<6)|(1<<3)|4), dout_TREADY_wdata=0 for 5 cycles -> dout_TVALID_wdata=1, dout_TDATA_wdata=0x3F, cmd_in_TREADY=0 throughout. Raise ready -> one beat transfers, then cmd_in_TREADY=1 next cycle.
- DROP rdata (cmd=0x03) with din_TVALID_rdata=1, data 0xAA -> din_TREADY_rdata=1, dout_TVALID_rdata=0 for that beat. The next beat 0xBB passes through.
- DROP resp pending while awaddr and raddr traffic flows -> awaddr and raddr stay in pass-through. Assert rst mid-wait -> FSM returns to IDLE, resp returns to pass-through, cmd_in_TREADY=1 after release.
- Invalid channel (cmd=(6<<3)|3) -> accepted in one cycle, no channel affected, cmd_in_TREADY stays 1.
